// File: rtl/display_scan_mux_if.sv
// Frame-data and scan-output bundle between value logic, the scan mux and
// the segment decoder / anode drivers.
interface display_scan_mux_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4
);
    logic                            enable;
    logic                            lz_blank_en;
    logic [NUM_DIGITS*DIGIT_W-1:0]   digits;
    logic [NUM_DIGITS-1:0]           decimal_point;
    logic [NUM_DIGITS-1:0]           digit_sel;
    logic [DIGIT_W-1:0]              digit_out;
    logic                            dp_out;
    logic                            frame_done;

    modport master (
        output enable, lz_blank_en, digits, decimal_point,
        input  digit_sel, digit_out, dp_out, frame_done
    );

    modport slave (
        input  enable, lz_blank_en, digits, decimal_point,
        output digit_sel, digit_out, dp_out, frame_done
    );
endinterface

// File: rtl/display_scan_mux.sv
// Self-scanning multi-digit 7-segment multiplexer: prescaled one-hot digit
// rotation, per-frame input capture and optional leading-zero blanking.
module display_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4,
    parameter int TICK_DIV   = 100000
) (
    input  logic               clk,
    input  logic               reset,
    display_scan_mux_if.slave  bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = NUM_DIGITS * DIGIT_W;
    localparam int OW = NUM_DIGITS + DIGIT_W + 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                state;
    logic [IW-1:0]         idx;
    logic [PW-1:0]         pcnt;
    logic [DW-1:0]         shadow_digits;
    logic [NUM_DIGITS-1:0] shadow_dp;
    logic [NUM_DIGITS-1:0] blank_vec;
    logic [NUM_DIGITS-1:0] blank_new;

    // A digit blanks only while every digit above it is blanked too, so the
    // chain is walked from the most significant digit down; digit 0 never blanks.
    function automatic logic [NUM_DIGITS-1:0] blank_calc(
        input logic            en,
        input logic [DW-1:0]   d,
        input logic [NUM_DIGITS-1:0] p
    );
        logic [NUM_DIGITS-1:0] b;
        logic                  above;
        b     = '0;
        above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            b[i]  = en && (d[i*DIGIT_W +: DIGIT_W] == '0) && !p[i] && above;
            above = b[i];
        end
        return b;
    endfunction

    // Packs {digit_sel, digit_out, dp_out} for slot k of a given frame.
    function automatic logic [OW-1:0] slot_view(
        input logic [IW-1:0]         k,
        input logic [DW-1:0]         d,
        input logic [NUM_DIGITS-1:0] p,
        input logic [NUM_DIGITS-1:0] b
    );
        logic [NUM_DIGITS-1:0] sel;
        logic [DIGIT_W-1:0]    dig;
        logic                  dpo;
        sel = '0;
        dig = '0;
        dpo = 1'b0;
        if (!b[k]) begin
            sel[k] = 1'b1;
            dig    = d[int'(k)*DIGIT_W +: DIGIT_W];
            dpo    = p[k];
        end
        return {sel, dig, dpo};
    endfunction

    assign blank_new = blank_calc(bus.lz_blank_en, bus.digits, bus.decimal_point);

    // Outputs are loaded from the post-edge state, so a capture edge already
    // presents slot 0 of the freshly captured frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            pcnt          <= '0;
            shadow_digits <= '0;
            shadow_dp     <= '0;
            blank_vec     <= '0;
            bus.digit_sel <= '0;
            bus.digit_out <= '0;
            bus.dp_out    <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        state         <= SCAN;
                        idx           <= '0;
                        pcnt          <= '0;
                        shadow_digits <= bus.digits;
                        shadow_dp     <= bus.decimal_point;
                        blank_vec     <= blank_new;
                        {bus.digit_sel, bus.digit_out, bus.dp_out} <=
                            slot_view('0, bus.digits, bus.decimal_point, blank_new);
                    end
                end
                SCAN: begin
                    if (!bus.enable) begin
                        state <= IDLE;
                        idx   <= '0;
                        pcnt  <= '0;
                        {bus.digit_sel, bus.digit_out, bus.dp_out} <= '0;
                    end else if (pcnt != PCNT_LAST) begin
                        pcnt <= pcnt + 1'b1;
                    end else if (idx != IDX_LAST) begin
                        pcnt <= '0;
                        idx  <= idx + 1'b1;
                        {bus.digit_sel, bus.digit_out, bus.dp_out} <=
                            slot_view(idx + 1'b1, shadow_digits, shadow_dp, blank_vec);
                    end else begin
                        pcnt           <= '0;
                        idx            <= '0;
                        shadow_digits  <= bus.digits;
                        shadow_dp      <= bus.decimal_point;
                        blank_vec      <= blank_new;
                        bus.frame_done <= 1'b1;
                        {bus.digit_sel, bus.digit_out, bus.dp_out} <=
                            slot_view('0, bus.digits, bus.decimal_point, blank_new);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
- Parametrised, self-scanning digit multiplexer for multi-digit 7-segment displays.
- Owns the refresh timing: it generates the rotating one-hot digit select from an internal prescaler, so upstream logic no longer has to drive a selector.
- Captures a complete frame of digit and decimal-point inputs at each frame start, so a display frame never mixes old and new values.
- Optionally blanks leading zeros. Sits between the timekeeping/ADC value logic and the segment decoder/anode drivers.

Parameters:
- NUM_DIGITS, 4, number of display digits; legal range ≥ 2.
- DIGIT_W, 4, width of each digit code.
- TICK_DIV, 100000, clock cycles spent on each digit slot; legal range ≥ 1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  run/stop scanning.
- lz_blank_en  input  1  enables leading-zero blanking.
- digits  input  NUM_DIGITS*DIGIT_W  packed digit values; digit i = bits [i*DIGIT_W +: DIGIT_W]; digit 0 is least significant.
- decimal_point  input  NUM_DIGITS  DP request per digit; bit i pairs with digit i.
- digit_sel  output  NUM_DIGITS  one-hot anode enable, active high; all zero when idle or when the current slot is blanked.
- digit_out  output  DIGIT_W  code of the digit in the current slot.
- dp_out  output  1  DP of the digit in the current slot.
- frame_done  output  1  one-cycle pulse when a new frame starts after a completed frame.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Reset has priority over enable.
- Reset values: digit_sel=0, digit_out=0, dp_out=0, frame_done=0; internal state idx=0, pcnt=0, running=0, shadow registers=0, blank vector=0.
- Output registers: every output is a flop, updated on the same edge as the state that drives it. No combinational path from any input to any output.
- Internal state:
  - idx: slot index, 0..NUM_DIGITS-1.
  - pcnt: prescaler, width max(1, $clog2(TICK_DIV)).
  - running: scan-active flag.
  - shadow_digits, shadow_dp: captured frame data.
  - blank_vec[NUM_DIGITS-1:0]: per-digit blank flags.
- Two states, IDLE (running=0) and SCAN (running=1).
- IDLE, enable=1: on that edge capture digits, decimal_point and blanking into the shadows; idx=0, pcnt=0, running=1. Outputs show slot 0 of the captured data from the same edge onward.
- SCAN, enable=1, pcnt<TICK_DIV-1: pcnt increments; everything else holds.
- SCAN, enable=1, pcnt==TICK_DIV-1:
  - pcnt=0.
  - If idx<NUM_DIGITS-1: idx+1.
  - If idx==NUM_DIGITS-1: idx wraps to 0, inputs are re-captured on this edge, and frame_done=1 for exactly the following cycle.
- SCAN, enable=0: on the next edge go to IDLE. All outputs go to 0, idx=0, pcnt=0; shadows hold.
- Re-enable restarts at slot 0 with a fresh capture. No frame_done pulse on a restart from IDLE.
- TICK_DIV=1: the slot advances on every enabled cycle.
- Blanking rule, evaluated at capture:
  - blank_vec[i]=1 only if lz_blank_en=1, digit i==0, decimal_point[i]==0, and i==NUM_DIGITS-1 or blank_vec[i+1]=1.
  - blank_vec[0] is always 0, so a value of zero shows "0".
- Slot decode for non-blanked slot k: digit_sel = 1<<k, digit_out = shadow digit k, dp_out = shadow_dp[k].
- Blanked slot: digit_sel=0, digit_out=0, dp_out=0. The slot still lasts TICK_DIV cycles, so brightness is uniform.
- Input changes mid-frame have no visible effect until the next frame capture.
- Digit codes pass through unmodified; there is no BCD range check.
- Reset mid-scan: returns to the reset values on the next edge regardless of enable.

Test Plan:
All scenarios use NUM_DIGITS=4, DIGIT_W=4, TICK_DIV=4.
1. Reset, then enable=1, lz_blank_en=0, digits=0x4321, dp=0 -> digit_sel sequence 0001,0010,0100,1000, 4 cycles each. digit_out 1,2,3,4. frame_done pulses 1 cycle after the 16th slot cycle, and digit_sel returns to 0001 on that edge.
2. Mid-frame: change digits 0x4321→0x8765 during slot 1 -> slots 2,3 still show 3,4. The next frame shows 5,6,7,8.
3. lz_blank_en=1, digits=0x0070 -> slots 3,2 blanked (digit_sel=0 for 4 cycles each), slot 1 shows 7, slot 0 shows 0. With digits=0x0000, only slot 0 is lit, showing 0. With dp=4'b0100 and digits=0x0000, slot 3 is blanked and slots 2,1,0 show 0 with dp_out=1 in slot 2.
4. Drop enable during slot 2 -> on the next edge all outputs are 0 and there is no frame_done pulse. Re-enable: slot 0 shows freshly captured data for 4 full cycles.
5. Assert reset while enable=1 in slot 3 -> outputs are 0 on the next edge. Releasing reset with enable=1 restarts at digit_sel=0001.
6. TICK_DIV=1 build, enable=1, digits=0x4321 -> digit_sel rotates every cycle and frame_done pulses every 4th cycle.
